// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction-timer datapath: tracker states,
// BCD constants and a digit-range helper.
package reaction_timer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        CELEBRATE = 2'd2
    } tracker_state_t;

    localparam logic [3:0]  BCD_BLANK    = 4'hF;
    localparam logic [15:0] BCD_MAX_TIME = {4'd9, 4'd9, 4'd9, 4'd9};

    function automatic logic bcd_time_valid(input logic [15:0] t);
        bcd_time_valid = (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
                         (t[7:4]   <= 4'd9) && (t[3:0]  <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd4_less_than.sv
// Combinational 4-digit BCD comparator; digit 3 is most significant.
// Lexicographic digit order equals numeric order for valid BCD.
module bcd4_less_than
    import reaction_timer_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        lt,
    output logic        eq
);

    always_comb begin
        lt = 1'b0;
        eq = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (eq) begin
                if (a[i*4 +: 4] < b[i*4 +: 4]) begin
                    lt = 1'b1;
                    eq = 1'b0;
                end else if (a[i*4 +: 4] > b[i*4 +: 4]) begin
                    eq = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/best_time_tracker.sv
// Keeps last and best reaction times, flags new records with a pulse and
// a blinking LED, and drives the display digits (last or best).
module best_time_tracker
    import reaction_timer_pkg::*;
#(
    parameter int unsigned BLINK_HALF    = 12500000,
    parameter int unsigned BLINK_TOGGLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_valid,
    input  logic [3:0] res_bcd3,
    input  logic [3:0] res_bcd2,
    input  logic [3:0] res_bcd1,
    input  logic [3:0] res_bcd0,
    input  logic       show_best,
    input  logic       clear_best,
    output logic [3:0] disp_bcd3,
    output logic [3:0] disp_bcd2,
    output logic [3:0] disp_bcd1,
    output logic [3:0] disp_bcd0,
    output logic       new_record,
    output logic       record_led,
    output logic       best_valid,
    output logic       bcd_err
);

    localparam int BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TOGGLE_W = $clog2(BLINK_TOGGLES + 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
    localparam logic [TOGGLE_W-1:0] TOGGLE_LAST = TOGGLE_W'(BLINK_TOGGLES - 1);

    tracker_state_t state, state_next;

    logic [15:0]         res_time;
    logic [15:0]         last_time;
    logic [15:0]         best_time;
    logic [15:0]         disp_time;
    logic [BLINK_W-1:0]  blink_cnt;
    logic [TOGGLE_W-1:0] toggle_cnt;
    logic                last_lt_best;
    logic                last_eq_best;
    logic                accept;
    logic                digits_ok;
    logic                is_record;
    logic                blink_wrap;
    logic                blink_done;

    assign res_time = {res_bcd3, res_bcd2, res_bcd1, res_bcd0};
    assign {disp_bcd3, disp_bcd2, disp_bcd1, disp_bcd0} = disp_time;

    bcd4_less_than u_cmp (
        .a  (last_time),
        .b  (best_time),
        .lt (last_lt_best),
        .eq (last_eq_best)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The initial LED rise counts as the first toggle, so an even toggle
    // count leaves the LED dark when the celebration finishes.
    always_comb begin
        state_next = state;
        accept     = result_valid && (state != COMPARE);
        digits_ok  = bcd_time_valid(res_time);
        is_record  = !best_valid || (last_lt_best && !last_eq_best);
        blink_wrap = (blink_cnt == BLINK_LAST);
        blink_done = blink_wrap && (toggle_cnt == TOGGLE_LAST);
        case (state)
            IDLE: begin
                if (accept) state_next = digits_ok ? COMPARE : IDLE;
            end
            COMPARE: begin
                if (clear_best)     state_next = IDLE;
                else if (is_record) state_next = CELEBRATE;
                else                state_next = IDLE;
            end
            CELEBRATE: begin
                if (accept)          state_next = digits_ok ? COMPARE : IDLE;
                else if (clear_best) state_next = IDLE;
                else if (blink_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_time  <= 16'h0000;
            best_time  <= BCD_MAX_TIME;
            best_valid <= 1'b0;
            new_record <= 1'b0;
            record_led <= 1'b0;
            bcd_err    <= 1'b0;
            blink_cnt  <= '0;
            toggle_cnt <= '0;
            disp_time  <= 16'h0000;
        end else begin
            new_record <= 1'b0;
            bcd_err    <= 1'b0;

            if (clear_best) begin
                best_time  <= BCD_MAX_TIME;
                best_valid <= 1'b0;
            end

            if (accept) begin
                if (digits_ok) last_time <= res_time;
                else           bcd_err   <= 1'b1;
            end

            if (state == COMPARE && !clear_best && is_record) begin
                best_time  <= last_time;
                best_valid <= 1'b1;
                new_record <= 1'b1;
                record_led <= 1'b1;
                blink_cnt  <= '0;
                toggle_cnt <= TOGGLE_W'(1);
            end

            if (state == CELEBRATE) begin
                if (accept || clear_best) begin
                    record_led <= 1'b0;
                    blink_cnt  <= '0;
                    toggle_cnt <= '0;
                end else if (blink_wrap) begin
                    blink_cnt  <= '0;
                    toggle_cnt <= toggle_cnt + TOGGLE_W'(1);
                    record_led <= blink_done ? 1'b0 : ~record_led;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end

            if (!show_best)      disp_time <= last_time;
            else if (best_valid) disp_time <= best_time;
            else                 disp_time <= {4{BCD_BLANK}};
        end
    end

endmodule

// File: doc/best_time_tracker.md
Name: best_time_tracker

Overview:
Downstream stage of the reaction-timer datapath. It consumes the 4-digit BCD reaction time each time a round stops. It keeps the last and the best (lowest) time, and flags a new record with a one-cycle pulse and a blinking LED. It drives the four BCD digits that feed the 7-segment decoders, selecting last or best time from the high-score switch.

Parameters:
BLINK_HALF, 12500000, clk cycles per LED half-period in CELEBRATE (0.25 s at 50 MHz)
BLINK_TOGGLES, 8, number of LED toggles before CELEBRATE ends (even, >=2)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
result_valid  input  1  one-cycle pulse: round stopped, res_bcd* stable
res_bcd3  input  4  result thousands digit (BCD)
res_bcd2  input  4  result hundreds digit
res_bcd1  input  4  result tens digit
res_bcd0  input  4  result units digit
show_best  input  1  level from SW[0]: 1 = display best time
clear_best  input  1  one-cycle pulse: forget stored best
disp_bcd3..disp_bcd0  output  4 each  digits to the BCD decoders (4'hF = blank code)
new_record  output  1  one-cycle pulse: accepted result beat best
record_led  output  1  blinking record indicator (LEDR[9])
best_valid  output  1  a best time is stored
bcd_err  output  1  one-cycle pulse: result rejected (digit > 9)

Behaviour:
- Clock, reset: one clock, clk. Reset is synchronous and active-high (rst sampled on posedge clk), with priority over all other inputs.
- Reset values:
  - state IDLE
  - last = 0000, best = 9999, best_valid = 0
  - new_record = 0, record_led = 0, bcd_err = 0, blink counters = 0
- States: IDLE, COMPARE, CELEBRATE.
- Accepting a result:
  - result_valid is accepted in IDLE and CELEBRATE, and ignored in COMPARE. COMPARE lasts one cycle and the upstream pulse spacing is far larger.
  - Accepted in CELEBRATE: the celebration aborts, record_led goes to 0 and the state goes to COMPARE.
- Acceptance at cycle t:
  - If any res digit is > 9: bcd_err = 1 during t+1, last is unchanged, the state goes to IDLE.
  - Otherwise: last <= res digits, and the state is COMPARE during t+1.
- COMPARE:
  - Digit-wise lexicographic compare (bcd3 is most significant). This equals a numeric compare for valid BCD, so no binary conversion is needed.
  - Record if best_valid == 0 or last < best (strict; a tie is not a record).
  - On a record: best <= last, best_valid <= 1, new_record = 1 during t+2, state CELEBRATE during t+2, record_led = 1 from t+2.
  - Otherwise: state IDLE at t+2, no pulse.
- CELEBRATE:
  - A cycle counter counts to BLINK_HALF-1, then record_led toggles and the counter wraps to 0.
  - After BLINK_TOGGLES toggles, record_led is 0 and the state is IDLE.
- clear_best:
  - Accepted in any state: best <= 9999, best_valid <= 0.
  - In CELEBRATE it also ends the celebration (LED 0, IDLE).
  - Simultaneous with result_valid: the clear applies first. The result is then accepted and, compared in the next cycle against the cleared state, always becomes a record.
  - Simultaneous with the COMPARE cycle: the clear wins and no record is written that cycle.
- Display (registered, updated every cycle):
  - show_best = 1 and best_valid = 1: best.
  - show_best = 1 and best_valid = 0: all 4'hF (blank).
  - show_best = 0: last.
  - show_best changes appear on disp one cycle later.
- Widths: blink counter is ceil(log2(BLINK_HALF)) bits; toggle counter is ceil(log2(BLINK_TOGGLES+1)) bits. No arithmetic overflow is possible; 9999 is the ceiling.

Decomposition:
- Shared package reaction_timer_pkg holds:
  - state encoding (IDLE, COMPARE, CELEBRATE)
  - BCD_BLANK = 4'hF
  - BCD_MAX_TIME = {4'd9, 4'd9, 4'd9, 4'd9}
- One natural sub-module: bcd4_less_than, a combinational 4-digit BCD comparator with outputs lt and eq. It is also reusable by a future multi-player ranking block.

Test Plan:
- rst, then result 0 3 4 5 -> new_record pulses 2 cycles after result_valid, best = 0345, best_valid = 1, record_led blinks 8 toggles (bench BLINK_HALF = 4), then IDLE.
- best 0345, result 0500 -> no new_record, last = 0500; show_best 0 shows 0500, show_best 1 shows 0345 one cycle after the switch changes.
- best 0345, result 0345 (tie) -> no record; result 0344 -> record, best = 0344.
- Result 0 1 A 2 -> bcd_err pulse, last and best unchanged, no new_record.
- clear_best and result_valid (0900) in the same cycle, with best 0200 -> best = 0900, new_record pulse; clear_best alone with show_best = 1 -> disp = FFFF.
- Mid-CELEBRATE new result 0100 (better) -> LED drops, new_record again 2 cycles later, blink restarts; rst mid-CELEBRATE -> all reset values next cycle.
